// File: rtl/seq_cnt_pkg.sv
// rtl/seq_cnt_pkg.sv - shared state encoding, index width helper and step sizes for the sequence counter
package seq_cnt_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int STEP_ONE = 1;
   localparam int STEP_TWO = 2;

   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/seq_cnt_table.sv
// rtl/seq_cnt_table.sv - programmable sequence table, identity-loaded on reset, one write and one read port
module seq_cnt_table
   import seq_cnt_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [WIDTH-1:0]           rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= WIDTH'(i);
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/seq_counter_prog.sv
// rtl/seq_counter_prog.sv - programmable sequence counter with skip, wrap and mark flag
// Optional hold-on-pause behaviour is built only when SEQ_CNT_PAUSE_EN is defined.
module seq_counter_prog
   import seq_cnt_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int MARK_SET = 3,
   parameter int MARK_CLR = 5
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       skip,
   input  logic                       pause,
   input  logic [$clog2(DEPTH):0]     seq_len,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           count_out,
   output logic [$clog2(DEPTH)-1:0]   idx_out,
   output logic                       busy,
   output logic                       wrap,
   output logic                       skip_flag,
   output logic                       wr_err
);

   localparam int IW = idx_w(DEPTH);
   localparam int LW = IW + 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [LW-1:0]    len_q, len_d;
   logic             busy_q, busy_d;
   logic             wrap_q, wrap_d;
   logic             flag_q, flag_d;
   logic             werr_q, werr_d;

   logic             tbl_wr_en;
   logic [IW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [LW-1:0]    len_clamped;
   logic [IW+1:0]    sum;
   logic [IW+1:0]    len_ext;
   logic [IW-1:0]    next_idx;

`ifndef SEQ_CNT_PAUSE_EN
   logic             pause_unused;
   assign pause_unused = pause;
`endif

   seq_cnt_table #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_table (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (tbl_wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // idx < len and step <= 2 <= len, so one conditional subtract implements the modulo
   always_comb begin
      len_clamped = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
      sum         = {2'b00, idx_q} + (skip ? (IW+2)'(STEP_TWO) : (IW+2)'(STEP_ONE));
      len_ext     = {1'b0, len_q};
      next_idx    = IW'((sum >= len_ext) ? (sum - len_ext) : sum);
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      idx_d     = idx_q;
      len_d     = len_q;
      busy_d    = busy_q;
      wrap_d    = 1'b0;
      flag_d    = flag_q;
      werr_d    = 1'b0;
      tbl_wr_en = 1'b0;
      rd_addr   = '0;

      case (state_q)
         ST_IDLE: begin
            tbl_wr_en = wr_en;
            if (start && (seq_len >= LW'(2))) begin
               state_d = ST_RUN;
               len_d   = len_clamped;
               idx_d   = '0;
               busy_d  = 1'b1;
               // a same-cycle write to entry 0 must be seen by the first value
               count_d = (wr_en && (wr_addr == '0)) ? wr_data : rd_data;
            end
         end
         ST_RUN: begin
            werr_d  = wr_en;
            rd_addr = next_idx;
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
               idx_d   = '0;
               busy_d  = 1'b0;
               flag_d  = 1'b0;
            end
`ifdef SEQ_CNT_PAUSE_EN
            else if (pause) begin
               wrap_d = 1'b0;
            end
`endif
            else begin
               idx_d   = next_idx;
               count_d = rd_data;
               wrap_d  = (sum >= len_ext);
               if (skip && (idx_q == IW'(MARK_SET))) begin
                  flag_d = 1'b1;
               end else if (skip && (idx_q == IW'(MARK_CLR))) begin
                  flag_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         busy_q  <= 1'b0;
         wrap_q  <= 1'b0;
         flag_q  <= 1'b0;
         werr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         busy_q  <= busy_d;
         wrap_q  <= wrap_d;
         flag_q  <= flag_d;
         werr_q  <= werr_d;
      end
   end

   assign count_out = count_q;
   assign idx_out   = idx_q;
   assign busy      = busy_q;
   assign wrap      = wrap_q;
   assign skip_flag = flag_q;
   assign wr_err    = werr_q;

endmodule

// File: doc/seq_counter_prog.md
SEQ_COUNTER_PROG -- requirements
Module: seq_counter_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each sequence value and count_out.
REQ-002 SHALL have parameter DEPTH, default 8, number of sequence table entries; power of 2, >= 2.
REQ-003 SHALL have parameter MARK_SET, default 3, index from which a skip sets skip_flag.
REQ-004 SHALL have parameter MARK_CLR, default 5, index from which a skip clears skip_flag.
REQ-005 SHALL have ports: clk  in  1  clock, rising edge; rstn  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  begin sequence; stop  in  1  abort to idle; skip  in  1  advance two entries instead of one.
REQ-007 SHALL have ports: pause  in  1  hold current entry (SEQ_CNT_PAUSE_EN only); seq_len  in  $clog2(DEPTH)+1  active entries, sampled at start.
REQ-008 SHALL have ports: wr_en  in  1  table write strobe; wr_addr  in  $clog2(DEPTH)  entry index; wr_data  in  WIDTH  entry value.
REQ-009 SHALL have ports: count_out  out  WIDTH  current value; idx_out  out  $clog2(DEPTH)  current index; busy  out  1  running; wrap  out  1  wrap pulse; skip_flag  out  1  mark flag; wr_err  out  1  rejected-write pulse.

Function
REQ-010 SHALL implement FSM states IDLE and RUN; all outputs registered.
REQ-011 In IDLE, start=1 with seq_len>=2 SHALL enter RUN next edge with idx_out=0, count_out=table[0], busy=1.
REQ-012 start with seq_len<2 SHALL be ignored; seq_len>DEPTH SHALL be clamped to DEPTH.
REQ-013 In RUN, each edge SHALL set idx = (idx + step) mod len, step = 2 if skip else 1; count_out = table[new idx].
REQ-014 wrap SHALL pulse high for exactly one cycle on the edge where idx + step >= len.
REQ-015 A skip taken while idx_out==MARK_SET SHALL set skip_flag; while idx_out==MARK_CLR SHALL clear it; otherwise it holds.
REQ-016 stop=1 in RUN SHALL return to IDLE next edge: count_out=0, idx_out=0, busy=0, skip_flag=0; stop beats skip and pause.
REQ-017 start in RUN SHALL be ignored; seq_len changes in RUN SHALL have no effect until the next start.
REQ-018 wr_en in IDLE SHALL write table[wr_addr]=wr_data; it becomes visible from the following cycle.
REQ-019 wr_en in RUN SHALL be dropped, and wr_err SHALL pulse high for one cycle.
REQ-020 start and wr_en in the same IDLE cycle SHALL commit the write first; if wr_addr==0, the new value SHALL appear as count_out.

Reset
REQ-021 rstn low SHALL asynchronously force IDLE, count_out=0, idx_out=0, busy=0, wrap=0, skip_flag=0, wr_err=0.
REQ-022 Reset SHALL load table[i]=i for all entries, and reset mid-RUN SHALL discard the sampled length.

Configuration
REQ-023 With SEQ_CNT_PAUSE_EN defined, pause=1 in RUN SHALL hold idx_out, count_out and skip_flag, suppress wrap, and ignore skip.
REQ-024 Without SEQ_CNT_PAUSE_EN, the pause port SHALL exist but be ignored, and no hold logic SHALL be synthesised.

Structure
REQ-025 State enum, index width function and step constants SHALL live in package seq_cnt_pkg.
REQ-026 Table storage and write port SHALL be sub-module seq_cnt_table; FSM and index arithmetic SHALL stay in seq_counter_prog.

Verification
REQ-027 Reset, write table {7,1,3,2,5,11,13,0}, seq_len=7, start, no skip -> count_out 7,1,3,2,5,11,13,7; wrap high on the 13->7 edge.
REQ-028 Same table, skip held every cycle from idx 0 -> idx 0,2,4,6,1,3,5,0; skip_flag sets after the skip from idx 3 and clears after the skip from idx 5.
REQ-029 seq_len=1 and start -> busy stays 0; seq_len=12 -> wraps after idx 7 (clamped to DEPTH=8).
REQ-030 wr_en while running -> table unchanged and wr_err one-cycle pulse; stop together with skip -> IDLE with count_out=0.
REQ-031 With SEQ_CNT_PAUSE_EN, pause for 3 cycles at idx 4 -> count_out=5 held for 3 cycles, no wrap, then resumes at 11.
REQ-032 rstn low mid-RUN -> all outputs 0 asynchronously, table restored to identity, next start gives count_out=0.
